// File: rtl/sum_window_accumulator_pkg.sv
// Shared definitions for timed-window blocks: state encoding and result-width derivation.
package sum_window_accumulator_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    ACCUM = 1'b1
  } win_state_e;

  // A window of 2**win_log2 full-scale samples needs exactly win_log2 extra bits.
  function automatic int unsigned sum_width(input int unsigned data_w,
                                            input int unsigned win_log2);
    return data_w + win_log2;
  endfunction

endpackage

// File: rtl/sum_window_accumulator_window_sample_counter.sv
// WIN_LOG2-bit sample counter with clear, enable and terminal-count flag.
module window_sample_counter #(
  parameter int unsigned WIN_LOG2 = 9
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                clear,
  input  logic                enable,
  output logic [WIN_LOG2-1:0] count,
  output logic                terminal
);

  // Terminal marks the enabled cycle that takes the count from all-ones back to zero.
  assign terminal = enable && (count == '1);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (clear) begin
      // Clearing on a qualified sample makes that sample the first of the new window.
      count <= enable ? WIN_LOG2'(1) : '0;
    end else if (enable) begin
      count <= count + WIN_LOG2'(1);
    end
  end

endmodule

// File: rtl/sum_window_accumulator.sv
// Windowed accumulator: sums 2**WIN_LOG2 qualified samples and strobes out the sum or mean.
module sum_window_accumulator
  import sum_window_accumulator_pkg::*;
#(
  parameter  int unsigned DATA_W   = 8,
  parameter  int unsigned WIN_LOG2 = 9,
  localparam int unsigned SUM_W    = sum_width(DATA_W, WIN_LOG2)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [DATA_W-1:0]   input_data,
  input  logic                data_valid,
  input  logic                data_start,
  input  logic                mode_avg,
  input  logic                continuous,
  output logic [SUM_W-1:0]    sum,
  output logic                sum_enable,
  output logic                busy,
  output logic [WIN_LOG2-1:0] sample_cnt
);

  win_state_e       state, state_next;
  logic [SUM_W-1:0] acc, acc_next, acc_plus, sample_ext;
  logic [SUM_W-1:0] sum_next;
  logic             strobe_next;
  logic             cnt_en, cnt_clear, cnt_tc, final_sample;

  assign sample_ext   = SUM_W'(input_data);
  assign acc_plus     = acc + sample_ext;
  assign busy         = (state == ACCUM);

  // The final sample wins over a coincident start: the window completes and the
  // counter wraps to zero instead of reloading.
  assign cnt_en       = (state == ACCUM) ? data_valid : (data_start && data_valid);
  assign final_sample = (state == ACCUM) && cnt_tc;
  assign cnt_clear    = data_start && !final_sample;

  window_sample_counter #(
    .WIN_LOG2(WIN_LOG2)
  ) u_counter (
    .clk     (clk),
    .reset   (reset),
    .clear   (cnt_clear),
    .enable  (cnt_en),
    .count   (sample_cnt),
    .terminal(cnt_tc)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next  = state;
    acc_next    = acc;
    sum_next    = sum;
    strobe_next = 1'b0;
    case (state)
      IDLE: begin
        if (data_start) begin
          state_next = ACCUM;
          acc_next   = data_valid ? sample_ext : '0;
        end
      end
      ACCUM: begin
        if (final_sample) begin
          sum_next    = mode_avg ? (acc_plus >> WIN_LOG2) : acc_plus;
          strobe_next = 1'b1;
          acc_next    = '0;
          if (!(continuous || data_start)) begin
            state_next = IDLE;
          end
        end else if (data_start) begin
          acc_next = data_valid ? sample_ext : '0;
        end else if (data_valid) begin
          acc_next = acc_plus;
        end
      end
      default: begin
        state_next = IDLE;
        acc_next   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc        <= '0;
      sum        <= '0;
      sum_enable <= 1'b0;
    end else begin
      acc        <= acc_next;
      sum        <= sum_next;
      sum_enable <= strobe_next;
    end
  end

endmodule
